// File: rtl/ieee754_subtract_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b), round-to-nearest-even.
// Denormal inputs and underflowing results flush to signed zero; alignment and normalization shift one bit per cycle.
module ieee754_subtract_seq #(
  parameter int ALIGN_MAX = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;

  localparam logic [7:0]  AMAX  = ALIGN_MAX[7:0];
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  state_t      state_q;
  logic [31:0] result_q;
  logic        sign_q, eff_sub_q;
  logic [8:0]  exp_q;
  logic [7:0]  cnt_q;
  logic [26:0] mx_q, my_q;
  logic [27:0] m_q;

  // Unpack: the operation is a + (-b); X holds the larger magnitude
  logic [31:0] nb, x, y;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [7:0]  dexp;

  assign nb     = {~b[31], b[30:0]};
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign x      = (nb[30:0] > a[30:0]) ? nb : a;
  assign y      = (nb[30:0] > a[30:0]) ? a : nb;
  assign dexp   = x[30:23] - y[30:23];

  logic        spec_hit;
  logic [31:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (a_nan || b_nan)       spec_res = QNAN;
    else if (a_inf && b_inf)  spec_res = (a[31] == b[31]) ? QNAN : a;
    else if (a_inf)           spec_res = a;
    else if (b_inf)           spec_res = nb;
    else if (a_zero && b_zero) spec_res = {a[31] & nb[31], 31'd0};
    else if (a_zero)          spec_res = nb;
    else if (b_zero)          spec_res = a;
    else                      spec_hit = 1'b0;
  end

  logic [27:0] sum;
  assign sum = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});

  // Round: bits [2:0] are guard, round, sticky
  logic        inc;
  logic [24:0] rsum;
  logic [8:0]  rexp;
  logic [31:0] rnd_res;

  assign inc     = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign rsum    = {1'b0, m_q[26:3]} + {24'd0, inc};
  assign rexp    = exp_q + {8'd0, rsum[24]};
  assign rnd_res = (rexp >= 9'd255) ? {sign_q, 8'hFF, 23'd0} : {sign_q, rexp[7:0], rsum[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      cnt_q     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      m_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (spec_hit) begin
            result_q <= spec_res;
            state_q  <= DONE;
          end else begin
            sign_q    <= x[31];
            eff_sub_q <= x[31] ^ y[31];
            exp_q     <= {1'b0, x[30:23]};
            mx_q      <= {1'b1, x[22:0], 3'b000};
            my_q      <= {1'b1, y[22:0], 3'b000};
            cnt_q     <= (dexp > AMAX) ? AMAX : dexp;
            state_q   <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt_q != 8'd0) begin
            my_q  <= {1'b0, my_q[26:2], my_q[1] | my_q[0]};
            cnt_q <= cnt_q - 8'd1;
          end
          if (cnt_q <= 8'd1) state_q <= ADDSUB;
        end
        ADDSUB: begin
          if (sum == 28'd0) begin
            result_q <= '0;
            state_q  <= DONE;
          end else begin
            m_q     <= sum;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (m_q[27]) begin
            m_q     <= {1'b0, m_q[27:2], m_q[1] | m_q[0]};
            exp_q   <= exp_q + 9'd1;
            state_q <= ROUND;
          end else if (!m_q[26]) begin
            if (exp_q == 9'd1) begin
              result_q <= {sign_q, 31'd0};
              state_q  <= DONE;
            end else begin
              m_q   <= {m_q[26:0], 1'b0};
              exp_q <= exp_q - 9'd1;
            end
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q <= rnd_res;
          state_q  <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ieee754_subtract_seq.sv
// Bench for ieee754_subtract_seq: directed spec cases, randomized ops against an exact-integer reference.
module tb_ieee754_subtract_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  ieee754_subtract_seq #(.ALIGN_MAX(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact reference: both significands placed on a 64-bit grid with 30 spare low bits,
  // so every retained bit is exact and rounding is done on the true remainder.
  function automatic logic [31:0] ref_sub(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] nb, x, y;
    longint unsigned X, Y, S, kept, rem, half;
    int ex, ey, d, p, e, sh;
    nb = {~bv[31], bv[30:0]};
    if ((av[30:23] == 8'hFF && av[22:0] != 0) || (bv[30:23] == 8'hFF && bv[22:0] != 0))
      return 32'h7FC00000;
    if (av[30:0] == 31'h7F800000 && bv[30:0] == 31'h7F800000)
      return (av[31] == bv[31]) ? 32'h7FC00000 : av;
    if (av[30:0] == 31'h7F800000) return av;
    if (bv[30:0] == 31'h7F800000) return nb;
    if (av[30:23] == 0 && bv[30:23] == 0) return (av[31] && !bv[31]) ? 32'h80000000 : 32'h0;
    if (av[30:23] == 0) return nb;
    if (bv[30:23] == 0) return av;
    if (av[30:0] >= bv[30:0]) begin x = av; y = nb; end
    else begin x = nb; y = av; end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d  = ex - ey;
    X  = 64'({1'b1, x[22:0]}) << 30;
    Y  = (d > 30) ? 64'd1 : ((64'({1'b1, y[22:0]}) << 30) >> d);
    S  = (x[31] == y[31]) ? X + Y : X - Y;
    if (S == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (S[i]) p = i;
    e = ex + p - 53;
    if (e <= 0) return {x[31], 31'd0};
    sh   = p - 23;
    kept = S >> sh;
    rem  = S & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept++;
    if (kept == (64'd1 << 24)) begin kept = kept >> 1; e++; end
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], 8'(e), kept[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    check("in_ready_wait", in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check("out_valid_seen", out_valid, 1);
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", result, res);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  logic [31:0] da [12] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                           32'h7F800000, 32'h7F7FFFFF, 32'h00000001, 32'h80000000, 32'h00000000,
                           32'h7FC00001, 32'h3F800000};
  logic [31:0] db [12] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h33800000, 32'h33000000,
                           32'h7F800000, 32'hFF7FFFFF, 32'h00000000, 32'h00000000, 32'h3F800000,
                           32'h3F800000, 32'hFF800000};
  logic [31:0] dr [12] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h3F7FFFFF, 32'h3F800000,
                           32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000, 32'hBF800000,
                           32'h7FC00000, 32'h7F800000};
  // 0 = latency not checked for that entry
  int          dl [12] = '{5, 3, 5, 0, 0, 1, 5, 1, 1, 1, 1, 1};
  logic [31:0] sp [6]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000,
                           32'h80000000, 32'h00400000};

  initial begin
    logic [31:0] res, av, bv;
    int lat, m, ea, eb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(da[i], db[i], 0, res, lat);
      check($sformatf("dir%0d", i), res, dr[i]);
      if (dl[i] != 0) check($sformatf("lat%0d", i), lat, dl[i]);
    end

    // Backpressure: result held for 10 cycles, then the next op must be accepted
    run_op(32'h40400000, 32'h3F800000, 10, res, lat);
    check("bp_result", res, 32'h40000000);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    run_op(32'h3F800000, 32'hBF800000, 0, res, lat);
    check("bp_next", res, 32'h40000000);

    // Reset during a 20-step alignment aborts at once
    a = 32'h49800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h49800000, 32'h3F800000, 0, res, lat);
    check("after_abort", res, 32'h497FFFF0);

    for (int n = 0; n < 300; n++) begin
      av = $urandom; bv = $urandom;
      m  = int'($urandom_range(0, 9));
      if (m < 7) begin
        ea = int'($urandom_range(1, 254));
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        av[30:23] = 8'(ea);
        bv[30:23] = 8'(eb);
        if (m == 5) bv = {av[31], av[30:0] ^ 31'($urandom_range(0, 7))};
      end else if (m == 7) begin
        if ($urandom_range(0, 1) == 1) av = sp[$urandom_range(0, 5)];
        else bv = sp[$urandom_range(0, 5)];
      end
      run_op(av, bv, int'($urandom_range(0, 2)), res, lat);
      check($sformatf("rnd%0d a=%h b=%h", n, av, bv), res, ref_sub(av, bv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ieee754_subtract_seq.md
Name: ieee754_subtract_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor: computes result = a - b.
- Uses a valid/ready handshake and rounds to nearest, ties to even.
- Intended as the subtract counterpart to the combinational adder in the FP datapath; iterative shifters keep area small at the cost of variable latency.
- Sits between the operand register file and the FP writeback stage.

Parameters:
- ALIGN_MAX, 26, maximum alignment shift cycles; larger exponent differences saturate to this count (smaller operand collapses into sticky).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  32  minuend, IEEE-754 single
- b  input  32  subtrahend, IEEE-754 single
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- result  output  32  a - b, IEEE-754 single
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, result=32'h0.
  - Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- Accept: when in_valid && in_ready in IDLE, register a and b with b's sign inverted. The operation is then an effective add of a and (-b).
- Unpack, same accept cycle:
  - exp==0 (zero/denormal) is flushed to signed zero.
  - Hidden bit is prepended.
  - Mantissa extended to 27 bits as {1, frac[22:0], G, R, S}.
  - Operands are swapped so X has the larger {exp, frac} magnitude.
  - Result sign = sign of X.
- Special cases go IDLE -> DONE directly (latency 1 cycle to out_valid):
  - Any NaN input -> 32'h7FC00000.
  - Inf - inf with equal signs (i.e. a and b are the same infinity) -> 32'h7FC00000.
  - One infinite operand -> that infinity, with b's sign inverted if b is the infinity.
  - Both operands zero: a - b gives -0 only when a=-0 and b=+0; otherwise +0.
  - Exactly one zero operand -> the other operand, with b's sign inverted if a is the zero.
- States: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE -> IDLE.
- ALIGN:
  - Shift Y right 1 bit per cycle; new bit0 = old bit1 | old bit0 (sticky).
  - Cycle count = min(exp_X - exp_Y, ALIGN_MAX).
  - Zero difference spends exactly 1 cycle in ALIGN with no shift.
- ADDSUB, 1 cycle:
  - 28-bit sum = X + Y if signs equal, else X - Y.
  - Exact zero difference -> result +0, go to DONE.
- NORM:
  - Carry (bit27) set -> 1 cycle: shift right 1 with sticky, exp+1.
  - Otherwise, while bit26==0: shift left 1 per cycle, exp-1.
  - If exp would reach 0 -> flush to signed zero, go to DONE.
  - Bit26 already set -> 1 cycle, no change.
- ROUND, 1 cycle:
  - Increment if G && (R || S || LSB).
  - Mantissa overflow -> frac=0, exp+1.
  - exp==255 after NORM or ROUND -> signed infinity (frac=0).
- DONE:
  - out_valid=1; result stable while out_ready=0.
  - On out_ready, return to IDLE; in_ready rises the next cycle. There is no accept in the same cycle as DONE handoff.
- Latency: 1 cycle for special cases. For normal operands, latency = 1 (accept) + align cycles + 1 (ADDSUB) + norm cycles + 1 (ROUND) to out_valid. Worst case is about 55 cycles.
- in_valid while busy is ignored; the producer must hold its operands until in_ready.

Test Plan:
- a=32'h40400000 (3.0), b=32'h3F800000 (1.0) -> result 32'h40000000; exactly 1 ALIGN cycle shift.
- a=32'h3F800000, b=32'h3F800000 -> 32'h00000000 (+0); a=32'h3F800000, b=32'hBF800000 -> 32'h40000000 via carry normalize.
- a=32'h3F800000, b=32'h33800000 (2^-24) -> 32'h3F7FFFFF (left-normalize path); b=32'h33000000 (2^-25) -> 32'h3F800000 (tie, round-to-even).
- Specials:
  - a=32'h7F800000, b=32'h7F800000 -> 32'h7FC00000.
  - a=32'h7F7FFFFF, b=32'hFF7FFFFF -> 32'h7F800000 (overflow).
  - a=32'h00000001 (denormal), b=0 -> +0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; release -> IDLE, next op accepted.
- Assert rst_n low during ALIGN of a 20-cycle-difference op -> outputs take reset values immediately (in_ready=1, out_valid=0, busy=0, result=32'h0); a following op returns a correct result.
